// File: rtl/sync_edge_det_multi.sv
// Multi-channel async input capture: synchroniser, glitch filter,
// mode-selectable edge detector, sticky flag and saturating counter.
module sync_edge_det_multi #(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int FILT_CYC = 1,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CH-1:0]       sig_in,
  input  logic [1:0]          mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       sig_sync,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       sticky,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  localparam int FW = $clog2(FILT_CYC) + 1;
  localparam logic [FW-1:0] FC_LAST = FW'(FILT_CYC - 1);

  typedef enum logic [1:0] {
    M_RISE = 2'b00,
    M_FALL = 2'b01,
    M_BOTH = 2'b10,
    M_OFF  = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic [FW-1:0]       fc_q, fc_d;
    logic                flt_q, flt_d;
    logic                flt_dly_q;
    logic                stk_q, stk_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sq;
    logic                rise, fall;
    logic                pls;

    assign sq = sync_q[SYNC_STG-1];

    // Filtered level only moves after FILT_CYC consecutive mismatches.
    always_comb begin
      sync_d = {sync_q[SYNC_STG-2:0], sig_in[i]};
      fc_d   = '0;
      flt_d  = flt_q;
      if (sq != flt_q) begin
        if (fc_q == FC_LAST) begin
          flt_d = sq;
        end else begin
          fc_d = fc_q + FW'(1);
        end
      end
    end

    assign rise = flt_q & ~flt_dly_q;
    assign fall = ~flt_q & flt_dly_q;

    always_comb begin
      pls = 1'b0;
      unique case (mode_s)
        M_RISE: pls = rise;
        M_FALL: pls = fall;
        M_BOTH: pls = rise | fall;
        M_OFF:  pls = 1'b0;
      endcase
    end

    // A pulse coinciding with clr still records the event.
    always_comb begin
      stk_d = pls | (stk_q & ~clr[i]);
      cnt_d = cnt_q;
      if (clr[i]) begin
        cnt_d = pls ? CNT_W'(1) : '0;
      end else if (pls && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        sync_q    <= '0;
        fc_q      <= '0;
        flt_q     <= 1'b0;
        flt_dly_q <= 1'b0;
        stk_q     <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync_q    <= sync_d;
        fc_q      <= fc_d;
        flt_q     <= flt_d;
        flt_dly_q <= flt_q;
        stk_q     <= stk_d;
        cnt_q     <= cnt_d;
      end
    end

    assign sig_sync[i]             = flt_q;
    assign pulse[i]                = pls;
    assign sticky[i]               = stk_q;
    assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule
